// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm sound path. The PWM generator on the
// transmit side and the tone detector on the receive side both pull their
// nominal period/tolerance numbers from here so the two never drift apart.
//
// Contents:
//   alarm_state_e         detector FSM states (SEARCH / MEASURE / LOCKED)
//   ALARM_NOMINAL_PERIOD  generator period in clk cycles (65536)
//   ALARM_NOMINAL_HIGH    generator high time in clk cycles (32768)
//   ALARM_*               default detector window, tolerance and timing
// ---------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } alarm_state_e;

    localparam int ALARM_NOMINAL_PERIOD = 65536;
    localparam int ALARM_NOMINAL_HIGH   = 32768;

    localparam int ALARM_CNT_W       = 18;
    localparam int ALARM_MIN_PERIOD  = 60000;
    localparam int ALARM_MAX_PERIOD  = 70000;
    localparam int ALARM_DUTY_TOL    = 2048;
    localparam int ALARM_LOCK_CYCLES = 4;
    localparam int ALARM_TIMEOUT     = 100000;
    localparam int ALARM_GLITCH_LEN  = 4;

endpackage

// File: rtl/pwm_deglitch.sv
// ---------------------------------------------------------------------------
// pwm_deglitch
// Stability filter for an already-synchronized single-bit input. The output
// only follows the input once the input has held a new value for GLITCH_LEN
// consecutive clocks, so pulses shorter than GLITCH_LEN never reach the
// output. Both edges are delayed by the same amount, which keeps measured
// high times unchanged.
//
// The whole module is only compiled when ALARM_DET_DEGLITCH_EN is defined,
// because the detector instantiates it only in that build.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset (output starts low)
//   in     in  1  synchronized input
//   out    out 1  filtered output
// Parameters:
//   GLITCH_LEN    consecutive stable cycles required before out changes
// ---------------------------------------------------------------------------
`ifdef ALARM_DET_DEGLITCH_EN
module pwm_deglitch #(
    parameter int GLITCH_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int CW = (GLITCH_LEN > 1) ? $clog2(GLITCH_LEN) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(GLITCH_LEN - 1);

    logic [CW-1:0] stable_cnt;

    // Count how long the input has disagreed with the current output.
    // Any return to agreement restarts the count, so a short pulse is
    // simply forgotten. The output flips on the GLITCH_LEN-th disagreeing
    // cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= 1'b0;
            stable_cnt <= '0;
        end else if (in != out) begin
            if (stable_cnt == STABLE_LAST) begin
                out        <= in;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule
`endif

// File: rtl/alarm_tone_detector.sv
// ---------------------------------------------------------------------------
// alarm_tone_detector
// Receive side of the alarm sound path. Samples the looped-back alarm square
// wave, measures period (rise to rise) and high time of every cycle, and
// asserts alarm_detected once LOCK_CYCLES consecutive cycles land inside the
// period window with close to 50% duty.
//
// Ports:
//   clk             in  1      system clock, everything on posedge
//   rst_n           in  1      asynchronous active-low reset
//   pwm_in          in  1      asynchronous square-wave input
//   alarm_detected  out 1      valid alarm tone locked
//   period_out      out CNT_W  last measured period in clk cycles
//   high_out        out CNT_W  high cycles within that period
//   meas_valid      out 1      one-cycle pulse when period_out/high_out update
//
// Build option:
//   ALARM_DET_DEGLITCH_EN  inserts pwm_deglitch after the synchronizer, so
//                          pulses shorter than GLITCH_LEN are ignored and
//                          edge latency grows from 2 to 2+GLITCH_LEN clocks.
// ---------------------------------------------------------------------------
module alarm_tone_detector
    import alarm_pkg::*;
#(
    parameter int CNT_W       = ALARM_CNT_W,
    parameter int MIN_PERIOD  = ALARM_MIN_PERIOD,
    parameter int MAX_PERIOD  = ALARM_MAX_PERIOD,
    parameter int DUTY_TOL    = ALARM_DUTY_TOL,
    parameter int LOCK_CYCLES = ALARM_LOCK_CYCLES,
    parameter int TIMEOUT     = ALARM_TIMEOUT,
    parameter int GLITCH_LEN  = ALARM_GLITCH_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             alarm_detected,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_P       = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_P       = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W+1:0] DUTY_LIM = (CNT_W+2)'(2 * DUTY_TOL);
    localparam int MATCH_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CYCLES - 1);

    logic                    sync_ff1;
    logic                    sync_ff2;
    logic                    s;
    logic                    s_prev;
    logic                    rise;
    logic [CNT_W-1:0]        per_cnt;
    logic [CNT_W-1:0]        hi_cnt;
    logic [CNT_W-1:0]        meas_period;
    logic signed [CNT_W+1:0] duty_diff;
    logic signed [CNT_W+1:0] duty_abs;
    logic                    qualify;
    logic                    timeout;
    logic [MATCH_W-1:0]      match_cnt;
    alarm_state_e            state;

    // Two-flop synchronizer; pwm_in has no relationship to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= pwm_in;
            sync_ff2 <= sync_ff1;
        end
    end

`ifdef ALARM_DET_DEGLITCH_EN
    pwm_deglitch #(
        .GLITCH_LEN (GLITCH_LEN)
    ) u_deglitch (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (sync_ff2),
        .out   (s)
    );
`else
    assign s = sync_ff2;
`endif

    // Previous sample of the (possibly filtered) input for rise detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

    assign rise = s & ~s_prev;

    // Free-running measurement counters, restarted by every rise. per_cnt
    // lands at 0 on the rise, so the period seen at the next rise is
    // per_cnt+1. hi_cnt lands at 1 because the rise cycle itself is high.
    // Both saturate so a dead input cannot wrap back into the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= '0;
            hi_cnt  <= CNT_W'(1);
        end else begin
            if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + 1'b1;
            end
            if (s && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end

    // Duty check works on |2*high - period| so no division is needed. The
    // two extra bits hold the sign and the doubled high time.
    assign meas_period = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + 1'b1;
    assign duty_diff   = $signed({1'b0, hi_cnt, 1'b0}) - $signed({2'b00, meas_period});
    assign duty_abs    = duty_diff[CNT_W+1] ? -duty_diff : duty_diff;
    assign qualify     = (meas_period >= MIN_P) && (meas_period <= MAX_P) &&
                         (duty_abs <= DUTY_LIM);
    assign timeout     = (per_cnt >= TIMEOUT_CNT);

    // Lock FSM with registered outputs. A rise always takes priority over
    // the timeout, so a period of exactly TIMEOUT+1 is still measured.
    // SEARCH only arms the measurement: the first rise has no earlier rise
    // to measure against, so nothing is captured there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SEARCH;
            match_cnt      <= '0;
            period_out     <= '0;
            high_out       <= '0;
            meas_valid     <= 1'b0;
            alarm_detected <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                SEARCH: begin
                    if (rise) begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_out <= meas_period;
                        high_out   <= hi_cnt;
                        meas_valid <= 1'b1;
                        if (qualify) begin
                            if (match_cnt == LOCK_LAST) begin
                                state          <= LOCKED;
                                alarm_detected <= 1'b1;
                                match_cnt      <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state          <= SEARCH;
                        match_cnt      <= '0;
                        alarm_detected <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_out <= meas_period;
                        high_out   <= hi_cnt;
                        meas_valid <= 1'b1;
                        if (!qualify) begin
                            state          <= MEASURE;
                            match_cnt      <= '0;
                            alarm_detected <= 1'b0;
                        end
                    end else if (timeout) begin
                        state          <= SEARCH;
                        match_cnt      <= '0;
                        alarm_detected <= 1'b0;
                    end
                end
                default: begin
                    state          <= SEARCH;
                    match_cnt      <= '0;
                    alarm_detected <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_tone_detector.sv
// ---------------------------------------------------------------------------
// tb_alarm_tone_detector
// Self-checking bench for alarm_tone_detector, run with scaled-down timing
// (period window 60..70, tolerance 4, timeout 100) so every scenario fits in
// a few thousand clocks. The waveform is described as a list of (high, low)
// segments; a reference model works on whole segments and predicts the
// measurement and lock state each rise should produce.
// ---------------------------------------------------------------------------
module tb_alarm_tone_detector;

    localparam int CNT_W = 8;
    localparam int MIN_P = 60;
    localparam int MAX_P = 70;
    localparam int TOL   = 4;
    localparam int LOCK  = 4;
    localparam int TMO   = 100;
    localparam int GLEN  = 4;
`ifdef ALARM_DET_DEGLITCH_EN
    localparam int EXTRA = GLEN;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic             alarm_detected;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;

    int checks   = 0;
    int failures = 0;

    // What the DUT has reported so far.
    int               mv_count    = 0;
    logic [CNT_W-1:0] last_period = '0;
    logic [CNT_W-1:0] last_high   = '0;

    // Reference model state.
    bit m_active    = 1'b0;
    bit m_locked    = 1'b0;
    int m_match     = 0;
    int m_prev_len  = 0;
    int m_prev_high = 0;

    alarm_tone_detector #(
        .CNT_W       (CNT_W),
        .MIN_PERIOD  (MIN_P),
        .MAX_PERIOD  (MAX_P),
        .DUTY_TOL    (TOL),
        .LOCK_CYCLES (LOCK),
        .TIMEOUT     (TMO),
        .GLITCH_LEN  (GLEN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pwm_in         (pwm_in),
        .alarm_detected (alarm_detected),
        .period_out     (period_out),
        .high_out       (high_out),
        .meas_valid     (meas_valid)
    );

    always #5 clk = ~clk;

    // Record every measurement pulse the DUT emits.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && meas_valid === 1'b1) begin
            mv_count    = mv_count + 1;
            last_period = period_out;
            last_high   = high_out;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            failures = failures + 1;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // A rise arrives: apply the timeout rule to the segment that just ended,
    // then either arm (first rise) or judge the completed period.
    task automatic modelRise(output bit exp_meas, output int exp_p, output int exp_h);
        bit q;
        exp_meas = 1'b0;
        exp_p    = 0;
        exp_h    = 0;
        if (m_active && m_prev_len >= TMO + 2) begin
            m_active = 1'b0;
            m_locked = 1'b0;
        end
        if (!m_active) begin
            m_active = 1'b1;
            m_match  = 0;
        end else begin
            exp_meas = 1'b1;
            exp_p    = m_prev_len;
            exp_h    = m_prev_high;
            q = (exp_p >= MIN_P) && (exp_p <= MAX_P) &&
                ((2 * exp_h - exp_p <= 2 * TOL) && (exp_p - 2 * exp_h <= 2 * TOL));
            if (m_locked) begin
                if (!q) begin
                    m_locked = 1'b0;
                    m_match  = 0;
                end
            end else if (q) begin
                m_match = m_match + 1;
                if (m_match >= LOCK) begin
                    m_locked = 1'b1;
                    m_match  = 0;
                end
            end else begin
                m_match = 0;
            end
        end
    endtask

    // One waveform segment: high for h cycles, then low for l cycles. With
    // glitch_at > 0 a 2-cycle low pulse is inserted that far into the high
    // phase (only used where the filter is expected to hide it).
    task automatic applyStimulus(input int h, input int l, input int glitch_at);
        int mv_before;
        bit em;
        int ep;
        int eh;
        int alarm_exp;
        mv_before = mv_count;
        modelRise(em, ep, eh);
        pwm_in = 1'b1;
        if (glitch_at > 0) begin
            repeat (glitch_at) @(negedge clk);
            pwm_in = 1'b0;
            repeat (2) @(negedge clk);
            pwm_in = 1'b1;
            repeat (h - glitch_at - 2) @(negedge clk);
        end else begin
            repeat (h) @(negedge clk);
        end
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
        m_prev_len  = h + l;
        m_prev_high = h;
        checkOutput("meas_count", mv_count - mv_before, em);
        if (em) begin
            checkOutput("period_out", last_period, ep);
            checkOutput("high_out", last_high, eh);
        end
        alarm_exp = (h + l >= TMO + 4 + EXTRA) ? 0 : int'(m_locked);
        checkOutput("alarm_detected", alarm_detected, alarm_exp);
    endtask

    task automatic relock();
        repeat (6) applyStimulus(32, 32, 0);
        checkOutput("relock", alarm_detected, 1);
    endtask

    initial begin
        int mv_before;
        bit em;
        int ep;
        int eh;

        // Reset held with a toggling input: everything stays at zero.
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        checkOutput("rst_alarm", alarm_detected, 0);
        checkOutput("rst_meas_valid", meas_valid, 0);
        checkOutput("rst_period", period_out, 0);
        checkOutput("rst_high", high_out, 0);
        @(negedge clk);
        pwm_in = 1'b0;
        rst_n  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_alarm", alarm_detected, 0);
        checkOutput("post_rst_meas", mv_count, 0);

        $display("[TB] nominal wave");
        repeat (6) applyStimulus(32, 32, 0);

        $display("[TB] one short period, then relock");
        applyStimulus(25, 25, 0);
        repeat (6) applyStimulus(32, 32, 0);

        $display("[TB] period and duty boundaries");
        applyStimulus(30, 30, 0);
        applyStimulus(35, 35, 0);
        applyStimulus(36, 28, 0);
        applyStimulus(28, 36, 0);
        applyStimulus(30, 29, 0);
        applyStimulus(35, 36, 0);
        applyStimulus(37, 27, 0);
        applyStimulus(27, 37, 0);
        applyStimulus(32, 32, 0);

        $display("[TB] 40/64 duty never locks");
        repeat (7) applyStimulus(40, 24, 0);

        $display("[TB] timeout boundary");
        relock();
        applyStimulus(50, 51, 0);
        applyStimulus(32, 32, 0);
        relock();
        applyStimulus(50, 52, 0);
        applyStimulus(32, 32, 0);

        $display("[TB] glitch inside high phase");
        relock();
`ifdef ALARM_DET_DEGLITCH_EN
        applyStimulus(32, 32, 10);
`else
        applyStimulus(10, 2, 0);
        applyStimulus(20, 32, 0);
`endif
        applyStimulus(32, 32, 0);

        $display("[TB] input stuck high");
        relock();
        applyStimulus(300, 30, 0);
        applyStimulus(32, 32, 0);

        $display("[TB] randomized segments");
        for (int i = 0; i < 25; i++) begin
            int p;
            int h;
            p = int'($urandom_range(56, 74));
            h = p / 2 + int'($urandom_range(0, 10)) - 5;
            applyStimulus(h, p - h, 0);
        end

        $display("[TB] input stuck low while locked");
        relock();
        mv_before = mv_count;
        modelRise(em, ep, eh);
        pwm_in = 1'b1;
        repeat (32) @(negedge clk);
        pwm_in = 1'b0;
        repeat (TMO + 3 + EXTRA - 32) @(negedge clk);
        checkOutput("stuck_low_meas", mv_count - mv_before, em);
        checkOutput("stuck_low_period", last_period, ep);
        checkOutput("alarm_before_timeout", alarm_detected, int'(m_locked));
        @(negedge clk);
        checkOutput("alarm_after_timeout", alarm_detected, 0);
        repeat (300) @(negedge clk);
        checkOutput("held_period_out", period_out, ep);
        checkOutput("held_high_out", high_out, eh);
        checkOutput("no_meas_while_dead", mv_count - mv_before, em);
        checkOutput("alarm_dead", alarm_detected, 0);
        m_active = 1'b0;
        m_locked = 1'b0;
        m_match  = 0;
        applyStimulus(32, 32, 0);

        $display("[TB] async reset mid-measurement");
        relock();
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_alarm", alarm_detected, 0);
        checkOutput("async_rst_meas_valid", meas_valid, 0);
        checkOutput("async_rst_period", period_out, 0);
        checkOutput("async_rst_high", high_out, 0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_active = 1'b0;
        m_locked = 1'b0;
        m_match  = 0;
        repeat (3) @(negedge clk);
        repeat (6) applyStimulus(32, 32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
